// File: rtl/mul_unit.sv
// mul_unit: multicycle unsigned shift-add multiplier feeding the Hi/Lo register.
// One multiplier bit is retired per RUN cycle; the 64-bit product is presented
// on MULAns together with a one-cycle Hi/Lo write command on HiLoSignal.
module mul_unit #(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [5:0]         Signal,
  input  logic [WIDTH-1:0]   dataA,
  input  logic [WIDTH-1:0]   dataB,
  output logic [2*WIDTH-1:0] MULAns,
  output logic [5:0]         HiLoSignal,
  output logic               busy,
  output logic               done
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);
  localparam logic [5:0] OP_MULTU = 6'b111111;
  localparam logic [5:0] OP_MADDU = 6'b111110;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state;
  logic [WIDTH-1:0]   mcand;
  logic [2*WIDTH-1:0] product;
  logic [CW-1:0]      counter;
  logic [5:0]         op;

  logic [WIDTH-1:0]   addend;
  logic [WIDTH:0]     sum;
  logic [2*WIDTH-1:0] next_product;

  // Only MULTU and MADDU start a multiply; everything else is ignored.
  function automatic logic is_valid_op(input logic [5:0] code);
    return (code == OP_MULTU) || (code == OP_MADDU);
  endfunction

  // One shift-add step: conditionally add the multiplicand to the upper half,
  // keep the carry as the new MSB and shift the whole product right by one.
  always_comb begin
    addend       = product[0] ? mcand : '0;
    sum          = {1'b0, product[2*WIDTH-1:WIDTH]} + {1'b0, addend};
    next_product = {sum, product[WIDTH-1:1]};
  end

  // Control FSM, datapath registers and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      mcand      <= '0;
      product    <= '0;
      counter    <= '0;
      op         <= 6'b000000;
      MULAns     <= '0;
      HiLoSignal <= 6'b000000;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done       <= 1'b0;
          HiLoSignal <= 6'b000000;
          if (start && is_valid_op(Signal)) begin
            mcand   <= dataA;
            op      <= Signal;
            product <= {{WIDTH{1'b0}}, dataB};
            counter <= '0;
            busy    <= 1'b1;
            state   <= RUN;
          end else begin
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        RUN: begin
          product <= next_product;
          counter <= counter + CW'(1);
          if (counter == LAST_STEP) begin
            // Final step: publish the finished product directly.
            MULAns     <= next_product;
            HiLoSignal <= op;
            done       <= 1'b1;
            state      <= DONE;
          end else begin
            state <= RUN;
          end
        end
        DONE: begin
          done       <= 1'b0;
          HiLoSignal <= 6'b000000;
          busy       <= 1'b0;
          state      <= IDLE;
        end
        default: begin
          done       <= 1'b0;
          HiLoSignal <= 6'b000000;
          busy       <= 1'b0;
          state      <= IDLE;
        end
      endcase
    end
  end

endmodule
